alu_seq_arb: RTL and testbench

Two-port sequencer/arbiter that shares the single clocked `alu` datapath between two requesters, e.g. an integer issue slot and an address/branch unit. Each requester hands over an opcode and two operands with a valid/ready handshake. The block grants one request at a time, drives the ALU's `opcode`/`a`/`b`/`enable` inputs for exactly one cycle, and waits the ALU's fixed latency. It then captures `out` and returns it on the granted requester's response channel. It is the only block driving the ALU ports.

---
 rtl/alu_seq_arb.sv | 106 ++++++++++
 tb/tb_alu_seq_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_arb.sv
// alu_seq_arb: two-requester sequencer sharing one clocked ALU; define ALU_SEQ_FIXED_PRIO_EN for fixed priority (req0 wins) instead of round-robin
module alu_seq_arb #(
  parameter int WIDTH = 32,
  parameter int OPW = 5,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req0_opcode,
  input  logic [OPW-1:0]   req1_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  output logic             resp1_valid,
  input  logic             resp0_ready,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp0_data,
  output logic [WIDTH-1:0] resp1_data,
  output logic             alu_enable,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             grant_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  state_t state;
  logic [3:0] cnt;
  logic [WIDTH-1:0] result;
  logic sel;
  logic idle_ok;
`ifdef ALU_SEQ_FIXED_PRIO_EN
  assign sel = !req0_valid;
`else
  logic last;
  assign sel = (req0_valid && req1_valid) ? !last : req1_valid;
`endif
  assign idle_ok = rst_n && (state == IDLE);
  assign req0_ready = idle_ok && req0_valid && !sel;
  assign req1_ready = idle_ok && req1_valid && sel;
  assign resp0_data = result;
  assign resp1_data = result;
  // grant, issue for one cycle, count out the ALU latency, then hold the response until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
`ifndef ALU_SEQ_FIXED_PRIO_EN
      last <= 1'b1;
`endif
      cnt <= '0;
      result <= '0;
      alu_enable <= 1'b0;
      alu_opcode <= '0;
      alu_a <= '0;
      alu_b <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      alu_enable <= 1'b0;
      case (state)
        IDLE: if (req0_valid || req1_valid) begin
          state <= ISSUE;
          grant_id <= sel;
`ifndef ALU_SEQ_FIXED_PRIO_EN
          last <= sel;
`endif
          busy <= 1'b1;
          alu_enable <= 1'b1;
          alu_opcode <= sel ? req1_opcode : req0_opcode;
          alu_a <= sel ? req1_a : req0_a;
          alu_b <= sel ? req1_b : req0_b;
        end
        ISSUE: begin
          state <= WAIT;
          cnt <= CNT_INIT;
        end
        WAIT: if (cnt == 4'd0) begin
          state <= RESP;
          result <= alu_out;
          resp0_valid <= !grant_id;
          resp1_valid <= grant_id;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (grant_id ? resp1_ready : resp0_ready) begin
          state <= IDLE;
          resp0_valid <= 1'b0;
          resp1_valid <= 1'b0;
          busy <= 1'b0;
          grant_id <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_arb.sv
// tb_alu_seq_arb: two DUT instances (LATENCY 1 and 4) checked every cycle against a transaction-timeline model
module tb_alu_seq_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic qv [2][2];
  logic qr [2][2];
  logic [4:0] qop [2][2];
  logic [31:0] qa [2][2];
  logic [31:0] qb [2][2];
  logic pv [2][2];
  logic pr [2][2];
  logic [31:0] pd [2][2];
  logic en [2];
  logic [4:0] aop [2];
  logic [31:0] aa [2];
  logic [31:0] ab [2];
  logic [31:0] aout [2];
  logic bsy [2];
  logic gid [2];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  alu_seq_arb #(.WIDTH(32), .OPW(5), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(qv[0][0]), .req1_valid(qv[0][1]), .req0_ready(qr[0][0]), .req1_ready(qr[0][1]),
    .req0_opcode(qop[0][0]), .req1_opcode(qop[0][1]),
    .req0_a(qa[0][0]), .req0_b(qb[0][0]), .req1_a(qa[0][1]), .req1_b(qb[0][1]),
    .resp0_valid(pv[0][0]), .resp1_valid(pv[0][1]), .resp0_ready(pr[0][0]), .resp1_ready(pr[0][1]),
    .resp0_data(pd[0][0]), .resp1_data(pd[0][1]),
    .alu_enable(en[0]), .alu_opcode(aop[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_out(aout[0]),
    .busy(bsy[0]), .grant_id(gid[0]));

  alu_seq_arb #(.WIDTH(32), .OPW(5), .LATENCY(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(qv[1][0]), .req1_valid(qv[1][1]), .req0_ready(qr[1][0]), .req1_ready(qr[1][1]),
    .req0_opcode(qop[1][0]), .req1_opcode(qop[1][1]),
    .req0_a(qa[1][0]), .req0_b(qb[1][0]), .req1_a(qa[1][1]), .req1_b(qb[1][1]),
    .resp0_valid(pv[1][0]), .resp1_valid(pv[1][1]), .resp0_ready(pr[1][0]), .resp1_ready(pr[1][1]),
    .resp0_data(pd[1][0]), .resp1_data(pd[1][1]),
    .alu_enable(en[1]), .alu_opcode(aop[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_out(aout[1]),
    .busy(bsy[1]), .grant_id(gid[1]));

  function automatic int lat(input int i);
    return i == 0 ? 1 : 4;
  endfunction

  function automatic logic [31:0] f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return op == 5'd0 ? a + b : op == 5'd1 ? a ^ b : (op == 5'd2 || op == 5'd3) ? a - b : a + b + 32'(op);
  endfunction

  // clocked ALU: result appears LATENCY edges after enable, garbage otherwise
  logic [31:0] pipe [2][4];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] <= en[i] ? f(aop[i], aa[i], ab[i]) : $urandom;
      for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
    end
  end
  assign aout[0] = pipe[0][0];
  assign aout[1] = pipe[1][3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [139:0] act, input logic [139:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  bit act_m [2];
  int t_m [2];
  bit g_m [2];
  bit last_m [2];
  logic [4:0] op_m [2];
  logic [31:0] a_m [2];
  logic [31:0] b_m [2];
  logic [31:0] res_m [2];
  logic [31:0] dat_m [2];
  int ng [2] = '{0, 0};
  int gr [2][8];
  int acc_cyc [2];
  int first_acc [2];
  int en_cyc [2];

  // model: t counts cycles since acceptance (1 = enable cycle); response due from t = LATENCY+2
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic w;
      logic rv;
      logic [139:0] expv;
      logic [139:0] actv;
`ifdef ALU_SEQ_FIXED_PRIO_EN
      w = !qv[i][0];
`else
      w = (qv[i][0] && qv[i][1]) ? !last_m[i] : qv[i][1];
`endif
      rv = act_m[i] && t_m[i] >= lat(i) + 2;
      expv = {rst_n && !act_m[i] && qv[i][0] && !w, rst_n && !act_m[i] && qv[i][1] && w,
              rv && !g_m[i], rv && g_m[i], act_m[i] && t_m[i] == 1, act_m[i], act_m[i] && g_m[i],
              op_m[i], a_m[i], b_m[i], dat_m[i], dat_m[i]};
      actv = {qr[i][0], qr[i][1], pv[i][0], pv[i][1], en[i], bsy[i], gid[i],
              aop[i], aa[i], ab[i], pd[i][0], pd[i][1]};
      if (cyc > 0) chk($sformatf("cyc%0d_u%0d", cyc, i), actv, expv);
      if (en[i]) en_cyc[i] <= cyc;
      for (int k = 0; k < 2; k++) begin
        if (qv[i][k] && qr[i][k]) begin
          if (ng[i] < 8) gr[i][ng[i]] <= k;
          if (ng[i] == 0) first_acc[i] <= cyc;
          ng[i] <= ng[i] + 1;
          acc_cyc[i] <= cyc;
        end
      end
      if (!rst_n) begin
        act_m[i] <= 1'b0; t_m[i] <= 0; g_m[i] <= 1'b0; last_m[i] <= 1'b1;
        op_m[i] <= '0; a_m[i] <= '0; b_m[i] <= '0; dat_m[i] <= '0;
      end else if (!act_m[i]) begin
        if (qv[i][0] || qv[i][1]) begin
          act_m[i] <= 1'b1; t_m[i] <= 1; g_m[i] <= w; last_m[i] <= w;
          op_m[i] <= qop[i][w]; a_m[i] <= qa[i][w]; b_m[i] <= qb[i][w];
          res_m[i] <= f(qop[i][w], qa[i][w], qb[i][w]);
        end
      end else if (t_m[i] >= lat(i) + 2 && pr[i][g_m[i]]) begin
        act_m[i] <= 1'b0; g_m[i] <= 1'b0;
      end else begin
        if (t_m[i] == lat(i) + 1) dat_m[i] <= res_m[i];
        t_m[i] <= t_m[i] + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int i, input int n0, input int k, output int tacc);
    for (int c = 0; c < 100 && ng[i] == n0; c++) tick();
    if (ng[i] == n0) chk($sformatf("accept_timeout_u%0d", i), 0, 1);
    qv[i][k] = 1'b0;
    tacc = acc_cyc[i];
  endtask

  task automatic send(input int i, input int k, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, output int tacc);
    int n0;
    n0 = ng[i];
    qop[i][k] = op; qa[i][k] = a; qb[i][k] = b; qv[i][k] = 1'b1;
    wait_acc(i, n0, k, tacc);
  endtask

  task automatic wait_resp(input int i, input int k, output int c, output logic [31:0] d);
    c = -1;
    d = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (pv[i][k]) begin
        c = cyc; d = pd[i][k];
        break;
      end
    end
    if (c < 0) chk($sformatf("resp_timeout_u%0d", i), 0, 1);
    tick();
  endtask

  task automatic drain;
    for (int c = 0; c < 100 && (bsy[0] || bsy[1]); c++) tick();
    chk("drain", {bsy[0], bsy[1]}, 0);
  endtask

  initial begin
    int tacc, c, rel, n0;
    logic [31:0] d;
    bit seen;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) begin
        qv[i][k] = 1'b1; pr[i][k] = 1'b1;
        qop[i][k] = 5'(k); qa[i][k] = 32'(100 + k); qb[i][k] = 32'(7 * k + 3);
      end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
    for (int c2 = 0; c2 < 300 && (ng[0] < 4 || ng[1] < 4); c2++) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (ng[i] >= 4) begin qv[i][0] = 1'b0; qv[i][1] = 1'b0; end
    end
    for (int i = 0; i < 2; i++) begin
      qv[i][0] = 1'b0; qv[i][1] = 1'b0;
      chk($sformatf("first_accept_u%0d", i), first_acc[i], rel);
      for (int n = 0; n < 4; n++)
`ifdef ALU_SEQ_FIXED_PRIO_EN
        chk($sformatf("tie_grant_u%0d_%0d", i, n), gr[i][n], 0);
`else
        chk($sformatf("tie_grant_u%0d_%0d", i, n), gr[i][n], n % 2);
`endif
    end
    drain();
    send(0, 0, 5'd2, 32'd4528, 32'd4500, tacc);
    wait_resp(0, 0, c, d);
    chk("single_en_cycle", en_cyc[0] - tacc, 1);
    chk("single_resp_cycle", c - tacc, 3);
    chk("single_data", d, 28);
    pr[0][1] = 1'b0;
    send(0, 1, 5'd0, 32'd1000, 32'd234, tacc);
    wait_resp(0, 1, c, d);
    chk("bp_data", d, 1234);
    qop[0][0] = 5'd1; qa[0][0] = 32'hF0F0; qb[0][0] = 32'h0FF0; qv[0][0] = 1'b1;
    n0 = ng[0];
    repeat (4) tick();
    chk("bp_req0_blocked", qr[0][0], 0);
    pr[0][1] = 1'b1;
    tick();
    chk("bp_idle_busy", bsy[0], 0);
    chk("bp_idle_ready", qr[0][0], 1);
    wait_acc(0, n0, 0, tacc);
    wait_resp(0, 0, c, d);
    chk("bp_next_data", d, 32'hFF00);
    send(1, 0, 5'd3, 32'd45562, 32'd45500, tacc);
    wait_resp(1, 0, c, d);
    chk("lat4_en_cycle", en_cyc[1] - tacc, 1);
    chk("lat4_resp_cycle", c - tacc, 6);
    chk("lat4_data", d, 62);
    send(1, 1, 5'd1, 32'd5, 32'd6, tacc);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      seen = seen | pv[1][0] | pv[1][1];
    end
    tick();
    chk("midrst_no_resp", seen, 0);
    send(1, 1, 5'd0, 32'd7, 32'd8, tacc);
    wait_resp(1, 1, c, d);
    chk("midrst_new_data", d, 15);
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 2; k++) begin
          qv[i][k] = ($urandom % 3) != 0;
          pr[i][k] = ($urandom % 4) != 0;
          qop[i][k] = 5'($urandom);
          qa[i][k] = $urandom;
          qb[i][k] = $urandom;
        end
      tick();
    end
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) begin qv[i][k] = 1'b0; pr[i][k] = 1'b1; end
    tick();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
